exc_sequencer: RTL and testbench



---
 rtl/exc_sequencer.sv | 139 +++++++++++++
 tb/tb_exc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Exception request sequencer in front of CP0: picks one trap, interrupt or eret,
// stalls and drains the pipe, pulses the commit to CP0, then pulses a flush to fetch.
module exc_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_sig,
  input  logic        rst_sig,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic        ext_irq,
  input  logic [31:0] pc_in,
  input  logic [31:0] status_in,
  output logic        exc_flag,
  output logic        eret_flag,
  output logic [4:0]  cause_val,
  output logic [31:0] pc_val,
  output logic        stall_out,
  output logic        flush_out,
  output logic        irq_pending,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_COMMIT   = 3'd2,
    S_ERET     = 3'd3,
    S_REDIRECT = 3'd4
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [4:0]             cause_q, cause_d;
  logic [31:0]            pc_q, pc_d;
  logic                   pend_q, pend_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_prev_q;

  logic irq_rise, irq_taken;
  logic brk_ok, sys_ok, teq_ok, irq_ok;
  logic unused_status;

  assign unused_status = ^status_in[31:5];

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      sync_q     <= '0;
      irq_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      irq_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise  = sync_q[SYNC_STAGES-1] & ~irq_prev_q;
  // Cause 0 is only ever latched for an interrupt, so it identifies the irq commit.
  assign irq_taken = (state_q == S_COMMIT) && (cause_q == 5'd0);
  assign pend_d    = irq_rise | (pend_q & ~irq_taken);

  assign brk_ok = status_in[0] & status_in[2] & break_req;
  assign sys_ok = status_in[0] & status_in[1] & syscall_req;
  assign teq_ok = status_in[0] & status_in[3] & teq_req;
  assign irq_ok = status_in[0] & status_in[4] & pend_q;

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cause_q <= 5'd0;
      pc_q    <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Requests are levels sampled only in IDLE; acceptance is implicit and is
  // visible as stall_out (or eret_flag) in the following cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    exc_flag  = 1'b0;
    eret_flag = 1'b0;
    stall_out = 1'b0;
    flush_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (brk_ok || sys_ok || teq_ok || irq_ok) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
          pc_d    = pc_in;
          if (brk_ok)      cause_d = 5'd9;
          else if (sys_ok) cause_d = 5'd8;
          else if (teq_ok) cause_d = 5'd13;
          else             cause_d = 5'd0;
        end else if (eret_req) begin
          state_d = S_ERET;
        end
      end
      S_DRAIN: begin
        stall_out = 1'b1;
        if (cnt_q == 4'd0) state_d = S_COMMIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_COMMIT: begin
        exc_flag  = 1'b1;
        stall_out = 1'b1;
        state_d   = S_REDIRECT;
      end
      S_ERET: begin
        eret_flag = 1'b1;
        stall_out = 1'b1;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush_out = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cause_val   = cause_q;
  assign pc_val      = pc_q;
  assign irq_pending = pend_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: hand-computed cycle-by-cycle expectations
// for traps, priority, gating, interrupt capture, eret and mid-sequence reset.
module tb_exc_sequencer;

  localparam int DRAIN = 2;
  localparam int SYNC  = 2;

  logic        clk_sig = 1'b0;
  logic        rst_sig = 1'b0;
  logic        syscall_req = 1'b0, break_req = 1'b0, teq_req = 1'b0, eret_req = 1'b0;
  logic        ext_irq = 1'b0;
  logic [31:0] pc_in = 32'd0, status_in = 32'd0;
  logic        exc_flag, eret_flag, stall_out, flush_out, irq_pending;
  logic [4:0]  cause_val;
  logic [31:0] pc_val;
  logic [2:0]  state_dbg_o;

  int tests_run = 0;
  int tests_failed = 0;

  exc_sequencer #(.DRAIN_CYCLES(DRAIN), .SYNC_STAGES(SYNC)) dut (
    .clk_sig(clk_sig), .rst_sig(rst_sig),
    .syscall_req(syscall_req), .break_req(break_req), .teq_req(teq_req),
    .eret_req(eret_req), .ext_irq(ext_irq), .pc_in(pc_in), .status_in(status_in),
    .exc_flag(exc_flag), .eret_flag(eret_flag), .cause_val(cause_val), .pc_val(pc_val),
    .stall_out(stall_out), .flush_out(flush_out), .irq_pending(irq_pending),
    .state_dbg_o(state_dbg_o)
  );

  always #5 clk_sig = ~clk_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected flag vector is {exc_flag, eret_flag, stall_out, flush_out}.
  task automatic chk_flags(input string tag, input logic [3:0] exp_v);
    chk(tag, {28'd0, exc_flag, eret_flag, stall_out, flush_out}, {28'd0, exp_v});
  endtask

  task automatic step();
    @(posedge clk_sig);
    #1;
  endtask

  task automatic clear_reqs();
    syscall_req = 1'b0;
    break_req   = 1'b0;
    teq_req     = 1'b0;
    eret_req    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_sig   = 1'b0;
    clear_reqs();
    ext_irq   = 1'b0;
    status_in = 32'd0;
    pc_in     = 32'd0;
    repeat (2) @(posedge clk_sig);
    #1;
    chk_flags({tag, "_rst_flags"}, 4'b0000);
    chk({tag, "_rst_cause"}, {27'd0, cause_val}, 32'd0);
    chk({tag, "_rst_pc"}, pc_val, 32'd0);
    chk({tag, "_rst_pend"}, {31'd0, irq_pending}, 32'd0);
    chk({tag, "_rst_state"}, {29'd0, state_dbg_o}, 32'd0);
    rst_sig = 1'b1;
  endtask

  // Caller presents the request; this steps through accept, drain, commit, redirect.
  task automatic run_exc(input string tag, input logic [4:0] cause, input logic [31:0] pc,
                         input logic irq_after, input logic pend_commit, input logic pend_redir);
    step();
    clear_reqs();
    ext_irq = irq_after;
    for (int i = 0; i < DRAIN; i++) begin
      chk_flags($sformatf("%s_drain%0d", tag, i), 4'b0010);
      step();
    end
    chk_flags({tag, "_commit"}, 4'b1010);
    chk({tag, "_cause"}, {27'd0, cause_val}, {27'd0, cause});
    chk({tag, "_pc"}, pc_val, pc);
    chk({tag, "_pend_commit"}, {31'd0, irq_pending}, {31'd0, pend_commit});
    step();
    chk_flags({tag, "_redirect"}, 4'b0001);
    chk({tag, "_pend_redir"}, {31'd0, irq_pending}, {31'd0, pend_redir});
    chk({tag, "_cause_hold"}, {27'd0, cause_val}, {27'd0, cause});
    step();
  endtask

  initial begin
    // Syscall: 3 stall cycles, commit in cycle 3, flush in cycle 4.
    do_reset("sys");
    status_in   = 32'h3;
    pc_in       = 32'h0040_0010;
    syscall_req = 1'b1;
    run_exc("sys", 5'd8, 32'h0040_0010, 1'b0, 1'b0, 1'b0);
    chk_flags("sys_idle", 4'b0000);
    chk("sys_pc_hold", pc_val, 32'h0040_0010);

    // Break beats syscall and teq; held requests re-accepted only after one IDLE cycle.
    status_in   = 32'h1F;
    pc_in       = 32'h0040_0020;
    break_req   = 1'b1;
    syscall_req = 1'b1;
    teq_req     = 1'b1;
    step();
    chk_flags("prio_drain0", 4'b0010);
    step();
    chk_flags("prio_drain1", 4'b0010);
    step();
    chk_flags("prio_commit", 4'b1010);
    chk("prio_cause", {27'd0, cause_val}, 32'd9);
    step();
    chk_flags("prio_redirect", 4'b0001);
    step();
    chk_flags("prio_idle", 4'b0000);
    step();
    chk_flags("prio_reaccept", 4'b0010);
    clear_reqs();
    step();
    step();
    chk_flags("prio_recommit", 4'b1010);
    chk("prio_recause", {27'd0, cause_val}, 32'd9);
    step();
    step();

    // Break disabled: syscall wins over teq and eret.
    status_in   = 32'h0B;
    pc_in       = 32'h0040_0030;
    break_req   = 1'b1;
    syscall_req = 1'b1;
    teq_req     = 1'b1;
    eret_req    = 1'b1;
    run_exc("sys2", 5'd8, 32'h0040_0030, 1'b0, 1'b0, 1'b0);

    // Teq only eligible trap.
    status_in   = 32'h09;
    pc_in       = 32'h0040_0040;
    syscall_req = 1'b1;
    teq_req     = 1'b1;
    run_exc("teq", 5'd13, 32'h0040_0040, 1'b0, 1'b0, 1'b0);

    // Only IE set: teq is ignored for 10 cycles.
    status_in = 32'h1;
    teq_req   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_flags($sformatf("gate_ie_%0d", i), 4'b0000);
    end
    // All enables but IE cleared: everything except eret is ignored.
    status_in   = 32'h1E;
    syscall_req = 1'b1;
    break_req   = 1'b1;
    repeat (3) step();
    chk_flags("gate_noie", 4'b0000);
    clear_reqs();

    // Interrupt: pending after SYNC+1 edges, commit with cause 0, cleared at commit.
    do_reset("irq");
    status_in = 32'h11;
    pc_in     = 32'h0040_0100;
    ext_irq   = 1'b1;
    step();
    step();
    chk("irq_pend_early", {31'd0, irq_pending}, 32'd0);
    step();
    chk("irq_pend_set", {31'd0, irq_pending}, 32'd1);
    chk_flags("irq_wait", 4'b0000);
    run_exc("irq", 5'd0, 32'h0040_0100, 1'b1, 1'b1, 1'b0);
    chk_flags("irq_no_retake0", 4'b0000);
    step();
    chk_flags("irq_no_retake1", 4'b0000);
    chk("irq_pend_low", {31'd0, irq_pending}, 32'd0);

    // Second edge applied in the first drain cycle reaches the sync output in COMMIT.
    do_reset("irq2");
    status_in = 32'h11;
    pc_in     = 32'h0040_0200;
    ext_irq   = 1'b1;
    repeat (3) step();
    chk("irq2_pend_set", {31'd0, irq_pending}, 32'd1);
    ext_irq = 1'b0;
    run_exc("irq2", 5'd0, 32'h0040_0200, 1'b1, 1'b1, 1'b1);
    chk_flags("irq2_idle", 4'b0000);
    step();
    chk_flags("irq2_retake", 4'b0010);

    // Eret is never gated; syscall-free IDLE takes it.
    do_reset("eret");
    eret_req = 1'b1;
    step();
    chk_flags("eret_pulse", 4'b0110);
    eret_req = 1'b0;
    step();
    chk_flags("eret_flush", 4'b0001);
    step();
    chk_flags("eret_idle", 4'b0000);

    // Reset during DRAIN aborts at once; aborted request is not committed later.
    status_in   = 32'h3;
    pc_in       = 32'h0040_0300;
    syscall_req = 1'b1;
    step();
    chk_flags("abort_drain", 4'b0010);
    #2;
    rst_sig = 1'b0;
    #1;
    chk_flags("abort_flags", 4'b0000);
    chk("abort_cause", {27'd0, cause_val}, 32'd0);
    chk("abort_pc", pc_val, 32'd0);
    chk("abort_state", {29'd0, state_dbg_o}, 32'd0);
    syscall_req = 1'b0;
    @(posedge clk_sig);
    #1;
    rst_sig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_flags($sformatf("abort_quiet_%0d", i), 4'b0000);
    end
    pc_in       = 32'h0040_0310;
    syscall_req = 1'b1;
    run_exc("abort_re", 5'd8, 32'h0040_0310, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Flag exclusivity holds on every cycle outside reset.
  always @(negedge clk_sig) begin
    if (rst_sig) begin
      assert (!(exc_flag && eret_flag) && !(flush_out && (exc_flag || eret_flag))) else begin
        tests_failed++;
        $error("FAIL flag_overlap: observed exc=%0b eret=%0b flush=%0b expected no overlap",
               exc_flag, eret_flag, flush_out);
      end
    end
  end

endmodule
